// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, visible-area enable and
// monitor syncs delayed to line up with the colour driver's registered output.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic [9:0] current_row,
    output logic [9:0] current_line,
    output logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             pix_tick_q, pix_tick_d;
    logic             enable_q, enable_d;
    logic             hs_raw_q, hs_raw_d;
    logic             vs_raw_q, vs_raw_d;
    logic             frame_start_q, frame_start_d;
    logic [10:0]      h_ext, v_ext;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pix_tick_d = (div_cnt_d == DIV_LAST);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        // Everything below is derived from next-state counters so it lands
        // in the same clock as the counter value it describes.
        h_ext         = {1'b0, h_cnt_d};
        v_ext         = {1'b0, v_cnt_d};
        enable_d      = (h_ext < H_VIS) && (v_ext < V_VIS);
        hs_raw_d      = !((h_ext >= HS_START) && (h_ext < HS_END));
        vs_raw_d      = !((v_ext >= VS_START) && (v_ext < VS_END));
        frame_start_d = pix_tick_q && (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_tick_q    <= 1'b0;
            enable_q      <= 1'b0;
            hs_raw_q      <= 1'b1;
            vs_raw_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_tick_q    <= pix_tick_d;
            enable_q      <= enable_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
            frame_start_q <= frame_start_d;
        end
    end

    generate
        if (SYNC_DELAY > 0) begin : g_dly
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                hs_pipe_d = SYNC_DELAY'({hs_pipe_q, hs_raw_q});
                vs_pipe_d = SYNC_DELAY'({vs_pipe_q, vs_raw_q});
            end

            always_ff @(posedge clk_in) begin
                if (reset) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign hsync = hs_pipe_q[SYNC_DELAY-1];
            assign vsync = vs_pipe_q[SYNC_DELAY-1];
        end else begin : g_nodly
            assign hsync = hs_raw_q;
            assign vsync = vs_raw_q;
        end
    endgenerate

    assign current_row  = h_cnt_q;
    assign current_line = v_cnt_q;
    assign enable       = enable_q;
    assign pix_tick     = pix_tick_q;
    assign frame_start  = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Three timing configurations driven by one randomized reset/run schedule and
// compared each clock against a closed-form raster model of clocks-since-reset.
module tb_vga_timing_gen;
    typedef struct {
        int d, s, hv, hf, hs, hb, vv, vf, vs, vb;
    } cfg_t;

    typedef struct {
        int row, line, en, hs, vs, pt, fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] a_row, a_line, b_row, b_line, c_row, c_line;
    logic a_en, a_hs, a_vs, a_pt, a_fs;
    logic b_en, b_hs, b_vs, b_pt, b_fs;
    logic c_en, c_hs, c_vs, c_pt, c_fs;

    vga_timing_gen u_a (
        .clk_in(clk), .reset(rst), .current_row(a_row), .current_line(a_line),
        .enable(a_en), .hsync(a_hs), .vsync(a_vs), .pix_tick(a_pt), .frame_start(a_fs));

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(0)
    ) u_b (
        .clk_in(clk), .reset(rst), .current_row(b_row), .current_line(b_line),
        .enable(b_en), .hsync(b_hs), .vsync(b_vs), .pix_tick(b_pt), .frame_start(b_fs));

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .SYNC_DELAY(2)
    ) u_c (
        .clk_in(clk), .reset(rst), .current_row(c_row), .current_line(c_line),
        .enable(c_en), .hsync(c_hs), .vsync(c_vs), .pix_tick(c_pt), .frame_start(c_fs));

    cfg_t ca, cb, cc;
    int   n_chk = 0;
    int   n_err = 0;
    int   k     = 0;   // clock edges since the last edge that sampled reset high

    // frame-level tallies for instance B (one clock per pixel)
    bit   b_seen = 0;
    int   b_en_cnt, b_hs_low, b_vs_low, b_period;
    bit   b_agg_on = 0;
    int   b_frames = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s k=%0d got=%0d exp=%0d t=%0t", tag, k, act, exp, $time);
        end
    endtask

    // Raster position (pixel index within the frame) after edge n, n>=1.
    function automatic int pos(input cfg_t c, input int n);
        int ht, vt, ticks;
        ht    = c.hv + c.hf + c.hs + c.hb;
        vt    = c.vv + c.vf + c.vs + c.vb;
        // a tick is visible one edge after it is raised; the tick flop is cleared by reset
        ticks = n / c.d - ((c.d == 1) ? 1 : 0);
        return ticks % (ht * vt);
    endfunction

    function automatic int hs_raw(input cfg_t c, input int p);
        int ht, h;
        ht = c.hv + c.hf + c.hs + c.hb;
        h  = p % ht;
        return (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? 0 : 1;
    endfunction

    function automatic int vs_raw(input cfg_t c, input int p);
        int ht, v;
        ht = c.hv + c.hf + c.hs + c.hb;
        v  = p / ht;
        return (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? 0 : 1;
    endfunction

    function automatic exp_t model(input cfg_t c, input int n);
        exp_t e;
        int ht, p;
        ht = c.hv + c.hf + c.hs + c.hb;
        e  = '{0, 0, 0, 1, 1, 0, 0};
        if (n >= 1) begin
            p      = pos(c, n);
            e.row  = p % ht;
            e.line = p / ht;
            e.en   = (e.row < c.hv && e.line < c.vv) ? 1 : 0;
            e.pt   = (n % c.d == c.d - 1) ? 1 : 0;
            e.fs   = (n >= 2 && ((n - 1) % c.d == c.d - 1) && p == 0) ? 1 : 0;
            if (n - c.s >= 1) begin
                e.hs = hs_raw(c, pos(c, n - c.s));
                e.vs = vs_raw(c, pos(c, n - c.s));
            end
        end
        return e;
    endfunction

    task automatic chk_inst(input string nm, input cfg_t c, input int row, input int line,
                            input int en, input int hs, input int vs, input int pt, input int fs);
        exp_t e;
        e = model(c, k);
        chk({nm, ".row"},   row,  e.row);
        chk({nm, ".line"},  line, e.line);
        chk({nm, ".en"},    en,   e.en);
        chk({nm, ".hsync"}, hs,   e.hs);
        chk({nm, ".vsync"}, vs,   e.vs);
        chk({nm, ".tick"},  pt,   e.pt);
        chk({nm, ".fs"},    fs,   e.fs);
    endtask

    task automatic b_frame_stats();
        if (b_fs) begin
            if (b_seen) begin
                chk("B.frame_en_ticks", b_en_cnt, 8 * 6);
                chk("B.frame_hs_low",   b_hs_low, 3 * 11);
                chk("B.frame_vs_low",   b_vs_low, 2 * 15);
                chk("B.frame_period",   b_period, 15 * 11);
                b_frames++;
            end
            b_seen   = 1;
            b_en_cnt = 0;
            b_hs_low = 0;
            b_vs_low = 0;
            b_period = 0;
        end
        b_en_cnt += int'(b_en);
        b_hs_low += int'(!b_hs);
        b_vs_low += int'(!b_vs);
        b_period++;
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        if (r) k = 0;
        else   k++;
        @(negedge clk);
        chk_inst("A", ca, int'(a_row), int'(a_line), int'(a_en), int'(a_hs), int'(a_vs), int'(a_pt), int'(a_fs));
        chk_inst("B", cb, int'(b_row), int'(b_line), int'(b_en), int'(b_hs), int'(b_vs), int'(b_pt), int'(b_fs));
        chk_inst("C", cc, int'(c_row), int'(c_line), int'(c_en), int'(c_hs), int'(c_vs), int'(c_pt), int'(c_fs));
        if (b_agg_on) b_frame_stats();
    endtask

    initial begin
        ca = '{4, 1, 640, 16, 96, 48, 480, 10, 2, 33};
        cb = '{1, 0, 8, 2, 3, 2, 6, 1, 2, 2};
        cc = '{3, 2, 5, 1, 2, 1, 4, 1, 1, 2};

        @(negedge clk);
        repeat (3) step(1'b1);

        // long uninterrupted run: A crosses several line wraps, B and C many frames
        b_agg_on = 1;
        repeat (8000) step(1'b0);
        b_agg_on = 0;
        chk("B.frames_seen", int'(b_frames >= 40), 1);

        // randomized mid-frame resets of 1..3 clocks between random-length runs
        for (int seg = 0; seg < 20; seg++) begin
            int run_len, rst_len;
            run_len = $urandom_range(2500, 20);
            rst_len = $urandom_range(3, 1);
            repeat (run_len) step(1'b0);
            repeat (rst_len) step(1'b1);
        end
        repeat (3300) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
